// File: rtl/addsub_serial.sv
// Digit-serial add/subtract engine: operands are consumed LSB-first, DIGIT bits
// per clock, with a registered carry and a held result behind a valid/ready pair.
module addsub_serial #(
    parameter int WIDTH = 4,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH:0]   d_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $fatal(1, "addsub_serial: WIDTH must be >=2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic             mode_q, mode_d, carry_q, carry_d;
    logic             asgn_q, asgn_d, bsgn_q, bsgn_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   d_q, d_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;

    logic [DIGIT:0]         slice;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic                   last;

    // carry_q is preloaded with the mode, so subtraction becomes A + ~B + 1
    assign slice   = {1'b0, a_q[DIGIT-1:0]}
                   + {1'b0, b_q[DIGIT-1:0] ^ {DIGIT{mode_q}}}
                   + {{DIGIT{1'b0}}, carry_q};
    assign res_cat = {slice[DIGIT-1:0], res_q};
    assign last    = (cnt_q == CW'(N - 1));

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        mode_d      = mode_q;
        carry_d     = carry_q;
        asgn_d      = asgn_q;
        bsgn_d      = bsgn_q;
        cnt_d       = cnt_q;
        d_d         = d_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    mode_d  = mode_i;
                    carry_d = mode_i;
                    asgn_d  = a_i[WIDTH-1];
                    bsgn_d  = b_i[WIDTH-1];
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                res_d   = res_cat[WIDTH+DIGIT-1:DIGIT];
                carry_d = slice[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    state_d = DONE;
                    // for subtraction the top bit is the borrow, i.e. inverted carry
                    d_d     = {slice[DIGIT] ^ mode_q, res_d};
                    zero_d  = ~|res_d;
                    ovf_d   = (asgn_q == (bsgn_q ^ mode_q)) && (res_d[WIDTH-1] != asgn_q);
                end
            end
            DONE: begin
                out_valid_o = 1'b1;
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            asgn_q  <= 1'b0;
            bsgn_q  <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            asgn_q  <= asgn_d;
            bsgn_q  <= bsgn_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign d_o    = d_q;
    assign zero_o = zero_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: unit 0 is WIDTH=4/DIGIT=1, unit 1 is WIDTH=8/DIGIT=4,
// both checked every cycle against an arithmetic reference model.
module tb_addsub_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iv[2], ir[2], md[2], ov[2], ordy[2], zf[2], of[2];
    logic [3:0] a0, b0;
    logic [7:0] a1, b1;
    logic [4:0] d0;
    logic [8:0] d1;
    logic [8:0] dd[2];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(4), .DIGIT(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
        .mode_i(md[0]), .a_i(a0), .b_i(b0), .out_valid_o(ov[0]),
        .out_ready_i(ordy[0]), .d_o(d0), .zero_o(zf[0]), .ovf_o(of[0]));

    addsub_serial #(.WIDTH(8), .DIGIT(4)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
        .mode_i(md[1]), .a_i(a1), .b_i(b1), .out_valid_o(ov[1]),
        .out_ready_i(ordy[1]), .d_o(d1), .zero_o(zf[1]), .ovf_o(of[1]));

    assign dd[0] = {4'b0, d0};
    assign dd[1] = d1;

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands; returns {ovf, zero, d[8:0]}.
    function automatic logic [10:0] ref_op(input int w, input bit m, input int a, input int b);
        int full, sa, sb, r, sr, d;
        bit z, o;
        full = 1 << w;
        sa = (a >= full / 2) ? a - full : a;
        sb = (b >= full / 2) ? b - full : b;
        r  = m ? a - b : a + b;
        sr = m ? sa - sb : sa + sb;
        d  = r & (2 * full - 1);
        z  = (d & (full - 1)) == 0;
        o  = (sr >= full / 2) || (sr < -(full / 2));
        return {o, z, d[8:0]};
    endfunction

    // Model: 0 = waiting for operands, 1 = computing (countdown), 2 = result held.
    int          ms[2] = '{0, 0};
    int          mc[2] = '{0, 0};
    logic [10:0] mexp[2];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int u = 0; u < 2; u++) ms[u] <= 0;
        end else begin
            for (int u = 0; u < 2; u++) begin
                case (ms[u])
                    0: if (iv[u]) begin
                        mexp[u] <= (u == 0) ? ref_op(4, md[0], int'(a0), int'(b0))
                                            : ref_op(8, md[1], int'(a1), int'(b1));
                        mc[u] <= (u == 0) ? 4 : 2;
                        ms[u] <= 1;
                    end
                    1: begin
                        mc[u] <= mc[u] - 1;
                        if (mc[u] == 1) ms[u] <= 2;
                    end
                    default: if (ordy[u]) ms[u] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("in_ready u%0d", u), ir[u], ms[u] == 0);
            chk($sformatf("out_valid u%0d", u), ov[u], ms[u] == 2);
            if (ms[u] == 2) begin
                chk($sformatf("model d u%0d", u), dd[u], mexp[u][8:0]);
                chk($sformatf("model zero u%0d", u), zf[u], mexp[u][9]);
                chk($sformatf("model ovf u%0d", u), of[u], mexp[u][10]);
            end
        end
    end

    // Present operands (current time must be just after an edge with the unit idle),
    // then check latency and the literal expected result.
    task automatic go(input int u, input bit m, input logic [7:0] a, input logic [7:0] b,
                      input int ed, input int eo, input int ez);
        int lat;
        lat = 0;
        if (u == 0) begin a0 = a[3:0]; b0 = b[3:0]; end
        else begin a1 = a; b1 = b; end
        md[u] = m;
        iv[u] = 1'b1;
        @(posedge clk); #1;
        iv[u] = 1'b0;
        if (u == 0) begin a0 = ~a0; b0 = ~b0; end
        else begin a1 = ~a1; b1 = ~b1; end
        for (int c = 1; c <= 20 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (ov[u]) lat = c;
        end
        chk($sformatf("latency u%0d", u), lat, (u == 0) ? 4 : 2);
        chk($sformatf("d u%0d", u), dd[u], ed);
        chk($sformatf("ovf u%0d", u), of[u], eo);
        chk($sformatf("zero u%0d", u), zf[u], ez);
    endtask

    task automatic op(input int u, input bit m, input logic [7:0] a, input logic [7:0] b,
                      input int ed, input int eo, input int ez);
        @(posedge clk); #1;
        go(u, m, a, b, ed, eo, ez);
    endtask

    int cnt;

    initial begin
        for (int u = 0; u < 2; u++) begin iv[u] = 0; md[u] = 0; ordy[u] = 1; end
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        #2;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst in_ready u%0d", u), ir[u], 1);
            chk($sformatf("rst out_valid u%0d", u), ov[u], 0);
            chk($sformatf("rst d u%0d", u), dd[u], 0);
            chk($sformatf("rst zero u%0d", u), zf[u], 0);
            chk($sformatf("rst ovf u%0d", u), of[u], 0);
        end
        #20 rst_n = 1'b1;

        // Backpressure: result and flags hold while the consumer stalls.
        ordy[0] = 1'b0;
        op(0, 1, 8'h3, 8'h5, 5'b11110, 0, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            a0 = 4'($urandom); b0 = 4'($urandom); iv[0] = ~iv[0]; md[0] = ~md[0];
            chk("hold d", d0, 5'b11110);
            chk("hold out_valid", ov[0], 1);
            chk("hold in_ready", ir[0], 0);
        end
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        chk("release out_valid", ov[0], 0);
        chk("release in_ready", ir[0], 1);

        go(0, 1, 8'h3, 8'h1, 5'b00010, 0, 0);
        op(0, 1, 8'h0, 8'h0, 5'b00000, 0, 1);
        op(0, 0, 8'hF, 8'hF, 5'b11110, 0, 0);
        op(0, 0, 8'h7, 8'h1, 5'b01000, 1, 0);
        op(0, 1, 8'h8, 8'h1, 5'b00111, 1, 0);

        // Asynchronous reset in the middle of a calculation.
        @(posedge clk); #1;
        a0 = 4'h3; b0 = 4'h5; md[0] = 1'b1; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", ov[0], 0);
        chk("async rst d", d0, 0);
        chk("async rst in_ready", ir[0], 1);
        #3 rst_n = 1'b1;
        go(0, 1, 8'h3, 8'h1, 5'b00010, 0, 0);

        op(1, 1, 8'h80, 8'h01, 9'h07F, 1, 0);
        op(1, 0, 8'hFF, 8'h01, 9'h100, 0, 1);
        op(1, 1, 8'h10, 8'h20, 9'h1F0, 0, 0);

        // Back-to-back on unit 1: one result every N+2 = 4 cycles.
        @(posedge clk); #1;
        md[1] = 1'b1; a1 = 8'h80; b1 = 8'h01; iv[1] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (ov[1]) cnt++;
            @(posedge clk); #1;
            a1 = 8'($urandom); b1 = 8'($urandom); md[1] = 1'($urandom);
        end
        iv[1] = 1'b0;
        chk("throughput results", cnt, 3);
        repeat (6) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
